// File: rtl/core_irq_pkg.sv
// core_irq_pkg
//   Shared types and constants for the core_irq processor slice: instruction
//   word width, opcode values, PC update modes, FSM state encoding, interrupt
//   vector defaults and the vector-address helper.
//   Instruction word layout: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
package core_irq_pkg;

  localparam int W_INST = 16;

  localparam int VEC_BASE_DEF   = 'hF0;
  localparam int VEC_STRIDE_DEF = 2;

  localparam logic [3:0] opNOP  = 4'h0;
  localparam logic [3:0] opLDI  = 4'h1;
  localparam logic [3:0] opADD  = 4'h2;
  localparam logic [3:0] opSUB  = 4'h3;
  localparam logic [3:0] opLDX  = 4'h4;
  localparam logic [3:0] opOUT  = 4'h5;
  localparam logic [3:0] opBR   = 4'h6;
  localparam logic [3:0] opWFI  = 4'hD;
  localparam logic [3:0] opHALT = 4'hE;
  localparam logic [3:0] opRETI = 4'hF;

  typedef enum logic [1:0] {
    PC_INC,
    PC_BRANCH,
    PC_HOLD
  } modePC;

  typedef enum logic [2:0] {
    FETCH,
    EXEC,
    IRQ_ENTRY,
    WFI,
    HALT
  } coreState;

  // Handler address for channel idx; callers truncate to their address width.
  function automatic logic [15:0] irq_vec(input logic [15:0] base,
                                          input logic [15:0] stride,
                                          input logic [3:0]  idx);
    return base + stride * {12'd0, idx};
  endfunction

endpackage

// File: rtl/core_irq_ctrl.sv
// core_irq_ctrl
//   Interrupt front end: per-channel rising-edge detect, sticky pending bits,
//   mask qualification and fixed lowest-index-first priority encoding.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   irq          : raw interrupt levels
//   mask         : 1 = channel may request service
//   clr          : strobe, clears the pending bit of the channel at index
//   any_req      : some pending channel is enabled
//   index        : lowest enabled pending channel (0 when none)
module core_irq_ctrl #(
  parameter int N_IRQ = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] irq,
  input  logic [N_IRQ-1:0] mask,
  input  logic             clr,
  output logic             any_req,
  output logic [3:0]       index
);

  logic [N_IRQ-1:0] prev;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] edge_det;
  logic [N_IRQ-1:0] req;
  logic [N_IRQ-1:0] clr_vec;

  assign edge_det = irq & ~prev;
  assign req      = pending & mask;
  assign any_req  = |req;
  assign clr_vec  = clr ? (N_IRQ'(1) << index) : '0;

  // Scan downwards so the lowest set index is the one left standing.
  always_comb begin
    index = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) index = 4'(i);
    end
  end

  // An edge arriving in the same cycle as the clear keeps the bit set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev    <= '0;
      pending <= '0;
    end else begin
      prev    <= irq;
      pending <= (pending & ~clr_vec) | edge_det;
    end
  end

endmodule

// File: rtl/core_irq.sv
// core_irq
//   Multi-cycle processor core with request/ack program fetch, a four-entry
//   register file, small ALU and a vectored, non-nesting interrupt controller.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   prog_req_o        : fetch request, prog_addr_o stable while high
//   prog_addr_o       : fetch address (the PC)
//   prog_ack_i        : completes a fetch, prog_data_i valid
//   prog_data_i       : instruction word
//   ext_data_i        : external data loaded by LDX
//   irq_i, irq_mask_i : interrupt levels and per-channel enables
//   result_o          : output register written by OUT
//   irq_ack_o         : one-hot pulse in the first handler fetch cycle
//   irq_active_o      : handler running
//   halt_o, wfi_o     : core halted / waiting for interrupt
//
// state     | meaning
// FETCH     | request instruction at PC, wait for ack
// EXEC      | execute IR, update PC, pick next state
// IRQ_ENTRY | save return PC, jump to channel vector
// WFI       | idle until an enabled interrupt is pending
// HALT      | stopped until reset
module core_irq
  import core_irq_pkg::*;
#(
  parameter int N          = 8,
  parameter int A          = 8,
  parameter int N_IRQ      = 4,
  parameter int RESET_VEC  = 0,
  parameter int VEC_BASE   = VEC_BASE_DEF,
  parameter int VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              prog_req_o,
  output logic [A-1:0]      prog_addr_o,
  input  logic              prog_ack_i,
  input  logic [W_INST-1:0] prog_data_i,
  input  logic [N-1:0]      ext_data_i,
  input  logic [N_IRQ-1:0]  irq_i,
  input  logic [N_IRQ-1:0]  irq_mask_i,
  output logic [N-1:0]      result_o,
  output logic [N_IRQ-1:0]  irq_ack_o,
  output logic              irq_active_o,
  output logic              halt_o,
  output logic              wfi_o
);

  coreState          state;
  logic [A-1:0]      pc;
  logic [A-1:0]      epc;
  logic [W_INST-1:0] ir;
  logic              irq_en;
  logic [N-1:0]      rf [4];

  logic              any_req;
  logic [3:0]        irq_index;

  logic [3:0]        op;
  logic [1:0]        rd;
  logic [1:0]        rs;
  logic [7:0]        imm;
  modePC             mode_pc;
  logic              rf_we;
  logic              out_we;
  logic              is_wfi;
  logic              is_halt;
  logic              is_reti;
  logic [N-1:0]      alu_y;
  logic [A-1:0]      pc_next;
  logic [A-1:0]      vec_pc;

  core_irq_ctrl #(.N_IRQ(N_IRQ)) u_ctrl (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .irq     (irq_i),
    .mask    (irq_mask_i),
    .clr     (state == IRQ_ENTRY),
    .any_req (any_req),
    .index   (irq_index)
  );

  assign prog_addr_o = pc;
  assign op          = ir[15:12];
  assign rd          = ir[11:10];
  assign rs          = ir[9:8];
  assign imm         = ir[7:0];
  assign vec_pc      = A'(irq_vec(16'(VEC_BASE), 16'(VEC_STRIDE), irq_index));

  always_comb begin
    mode_pc = PC_INC;
    rf_we   = 1'b0;
    out_we  = 1'b0;
    is_wfi  = 1'b0;
    is_halt = 1'b0;
    is_reti = 1'b0;
    alu_y   = '0;
    case (op)
      opNOP:  ;
      opLDI:  begin rf_we = 1'b1; alu_y = N'(imm); end
      opADD:  begin rf_we = 1'b1; alu_y = rf[rd] + rf[rs]; end
      opSUB:  begin rf_we = 1'b1; alu_y = rf[rd] - rf[rs]; end
      opLDX:  begin rf_we = 1'b1; alu_y = ext_data_i; end
      opOUT:  out_we = 1'b1;
      opBR:   mode_pc = PC_BRANCH;
      opWFI:  is_wfi = 1'b1;
      opHALT: begin is_halt = 1'b1; mode_pc = PC_HOLD; end
      opRETI: is_reti = 1'b1;
      default: ;
    endcase
  end

  // Branch offset is the sign-extended immediate; all PC arithmetic wraps.
  always_comb begin
    case (mode_pc)
      PC_BRANCH: pc_next = pc + A'($signed(imm));
      PC_HOLD:   pc_next = pc;
      default:   pc_next = pc + A'(1);
    endcase
  end

  always_ff @(posedge clk_i) begin
    irq_ack_o <= '0;
    if (rst_i) begin
      state        <= FETCH;
      pc           <= A'(RESET_VEC);
      epc          <= '0;
      ir           <= '0;
      irq_en       <= 1'b1;
      prog_req_o   <= 1'b0;
      irq_active_o <= 1'b0;
      halt_o       <= 1'b0;
      wfi_o        <= 1'b0;
      result_o     <= '0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          prog_req_o <= 1'b1;
          // An ack is only meaningful once the request is actually out.
          if (prog_req_o && prog_ack_i) begin
            ir         <= prog_data_i;
            prog_req_o <= 1'b0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (rf_we)  rf[rd]   <= alu_y;
          if (out_we) result_o <= rf[rs];
          if (is_reti) begin
            pc           <= epc;
            irq_en       <= 1'b1;
            irq_active_o <= 1'b0;
          end else begin
            pc <= pc_next;
          end
          // RETI re-enables interrupts immediately, so a channel left pending
          // during the handler is taken before the return address is fetched.
          if (is_halt) begin
            halt_o <= 1'b1;
            state  <= HALT;
          end else if (is_wfi) begin
            wfi_o <= 1'b1;
            state <= WFI;
          end else if ((irq_en || is_reti) && any_req) begin
            state <= IRQ_ENTRY;
          end else begin
            prog_req_o <= 1'b1;
            state      <= FETCH;
          end
        end
        IRQ_ENTRY: begin
          if (any_req) begin
            epc          <= pc;
            pc           <= vec_pc;
            irq_ack_o    <= N_IRQ'(1) << irq_index;
            irq_en       <= 1'b0;
            irq_active_o <= 1'b1;
          end
          prog_req_o <= 1'b1;
          state      <= FETCH;
        end
        WFI: begin
          if (any_req) begin
            wfi_o <= 1'b0;
            if (irq_en) begin
              state <= IRQ_ENTRY;
            end else begin
              prog_req_o <= 1'b1;
              state      <= FETCH;
            end
          end
        end
        HALT: ;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_core_irq.sv
module tb_core_irq;
  import core_irq_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        prog_req_o;
  logic [7:0]  prog_addr_o;
  logic        prog_ack_i;
  logic [15:0] prog_data_i;
  logic [7:0]  ext_data_i;
  logic [3:0]  irq_i;
  logic [3:0]  irq_mask_i;
  logic [7:0]  result_o;
  logic [3:0]  irq_ack_o;
  logic        irq_active_o;
  logic        halt_o;
  logic        wfi_o;

  always #5 clk_i = ~clk_i;

  core_irq #(.N(8), .A(8), .N_IRQ(4), .RESET_VEC(0), .VEC_BASE('hF0), .VEC_STRIDE(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .prog_req_o(prog_req_o), .prog_addr_o(prog_addr_o),
    .prog_ack_i(prog_ack_i), .prog_data_i(prog_data_i), .ext_data_i(ext_data_i),
    .irq_i(irq_i), .irq_mask_i(irq_mask_i), .result_o(result_o), .irq_ack_o(irq_ack_o),
    .irq_active_o(irq_active_o), .halt_o(halt_o), .wfi_o(wfi_o)
  );

  typedef struct packed {
    logic [7:0] addr;
    logic [3:0] ack;
    logic       act;
  } fetch_t;

  logic [15:0] mem [256];
  fetch_t      obs_q[$];
  fetch_t      exp_q[$];
  int          ws_addr = 0;
  int          ws_n = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  // Program memory: acks each request (after optional wait states) and logs
  // the completed fetch with any irq_ack_o seen during it.
  initial begin
    int wcnt;
    logic [3:0] ack_acc;
    wcnt = 0;
    ack_acc = '0;
    prog_ack_i = 1'b0;
    prog_data_i = '0;
    forever begin
      @(negedge clk_i);
      #1;
      if (rst_i || !prog_req_o) begin
        prog_ack_i = 1'b0;
        wcnt = 0;
        ack_acc = '0;
      end else begin
        ack_acc = ack_acc | irq_ack_o;
        if (prog_addr_o == ws_addr[7:0] && wcnt < ws_n) begin
          prog_ack_i = 1'b0;
          wcnt++;
        end else begin
          if (prog_addr_o == ws_addr[7:0]) ws_n = 0;
          prog_ack_i = 1'b1;
          prog_data_i = mem[prog_addr_o];
          obs_q.push_back(fetch_t'{prog_addr_o, ack_acc, irq_active_o});
        end
      end
    end
  end

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) mem[i] = ins(opNOP, 2'd0, 2'd0, 8'h00);
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [3:0] k, input logic act);
    exp_q.push_back(fetch_t'{a, k, act});
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    irq_i = '0;
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    ws_n = 0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_obs(input int n, output bit to);
    int k;
    k = 0;
    to = 1'b0;
    while (obs_q.size() < n) begin
      @(negedge clk_i);
      k++;
      if (k > 400) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_fetch(input logic [7:0] a, inout bit to);
    int k;
    k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while (!(prog_req_o && prog_addr_o == a) && k < 300);
    if (!(prog_req_o && prog_addr_o == a)) to = 1'b1;
  endtask

  task automatic test_reset();
    logic exp_req;
    bit to;
    fill_nop();
    rst_i = 1'b1; irq_i = '0; irq_mask_i = '0; ext_data_i = '0;
    @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if ({prog_req_o, prog_addr_o, result_o, irq_ack_o, irq_active_o, halt_o, wfi_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b addr=%h res=%h ack=%b act=%b halt=%b wfi=%b, required all 0",
               prog_req_o, prog_addr_o, result_o, irq_ack_o, irq_active_o, halt_o, wfi_o);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    obs_q.delete();
    exp_q.delete();
    n_checks++;
    if (prog_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cycle0_req: got %b, required 0", prog_req_o);
    end
    for (int k = 0; k < 3; k++) push_exp(8'(k), 4'b0, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_i);
      exp_req = (c % 2 == 1);
      n_checks++;
      if (prog_req_o !== exp_req || (exp_req && prog_addr_o !== 8'((c - 1) / 2))) begin
        n_fail++;
        $display("FAIL reset_fetch_timing: cycle %0d req=%b addr=%h, required req=%b addr=%h",
                 c, prog_req_o, prog_addr_o, exp_req, 8'((c - 1) / 2));
      end
    end
    wait_obs(exp_q.size(), to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL reset_timeout: %0d fetches, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      fetch_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL reset_fetch: got %h/%b/%b, required %h/%b/%b", o.addr, o.ack, o.act, e.addr, e.ack, e.act); end
    end
  endtask

  task automatic test_wait_states();
    int req_cycles;
    bit early;
    bit to;
    fill_nop();
    mem[0] = ins(opLDI, 2'd0, 2'd0, 8'h5A);
    mem[1] = ins(opOUT, 2'd0, 2'd0, 8'h00);
    do_reset();
    ws_addr = 1; ws_n = 3;
    for (int k = 0; k < 3; k++) push_exp(8'(k), 4'b0, 1'b0);
    req_cycles = 0; early = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (prog_req_o && prog_addr_o == 8'h01) begin
        req_cycles++;
        if (result_o !== 8'h00) early = 1'b1;
      end
    end
    n_checks++;
    if (req_cycles != 4) begin n_fail++; $display("FAIL wait_req_cycles: got %0d, required 4", req_cycles); end
    n_checks++;
    if (early) begin n_fail++; $display("FAIL wait_early_write: result changed during wait, required 00"); end
    n_checks++;
    if (result_o !== 8'h5A) begin n_fail++; $display("FAIL wait_result: got %h, required 5a", result_o); end
    wait_obs(exp_q.size(), to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL wait_timeout: %0d fetches, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      fetch_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL wait_fetch: got %h/%b/%b, required %h/%b/%b", o.addr, o.ack, o.act, e.addr, e.ack, e.act); end
    end
  endtask

  task automatic test_priority();
    bit to;
    fill_nop();
    mem[8'hF2] = ins(opRETI, 2'd0, 2'd0, 8'h00);
    mem[8'hF6] = ins(opRETI, 2'd0, 2'd0, 8'h00);
    do_reset();
    irq_mask_i = 4'b1111;
    for (int k = 0; k < 6; k++) push_exp(8'(k), 4'b0, 1'b0);
    push_exp(8'hF2, 4'b0010, 1'b1);
    push_exp(8'hF6, 4'b1000, 1'b1);
    push_exp(8'h06, 4'b0000, 1'b0);
    push_exp(8'h07, 4'b0000, 1'b0);
    to = 1'b0;
    wait_fetch(8'h05, to);
    irq_i = 4'b1010;
    wait_obs(exp_q.size(), to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL prio_timeout: %0d fetches, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      fetch_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL prio_fetch: got %h/%b/%b, required %h/%b/%b", o.addr, o.ack, o.act, e.addr, e.ack, e.act); end
    end
  endtask

  task automatic test_masking();
    bit to;
    fill_nop();
    mem[8'hF4] = ins(opRETI, 2'd0, 2'd0, 8'h00);
    do_reset();
    irq_mask_i = 4'b1011;
    for (int k = 0; k < 7; k++) push_exp(8'(k), 4'b0, 1'b0);
    push_exp(8'hF4, 4'b0100, 1'b1);
    push_exp(8'h07, 4'b0000, 1'b0);
    push_exp(8'h08, 4'b0000, 1'b0);
    to = 1'b0;
    wait_fetch(8'h02, to);
    irq_i = 4'b0100;
    wait_fetch(8'h06, to);
    irq_mask_i = 4'b1111;
    wait_obs(exp_q.size(), to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL mask_timeout: %0d fetches, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      fetch_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL mask_fetch: got %h/%b/%b, required %h/%b/%b", o.addr, o.ack, o.act, e.addr, e.ack, e.act); end
    end
  endtask

  task automatic test_wfi();
    int wcount;
    int k;
    bit fetched;
    bit to;
    // Interrupts enabled: wake straight into the channel-0 handler.
    fill_nop();
    mem[3] = ins(opWFI, 2'd0, 2'd0, 8'h00);
    mem[8'hF0] = ins(opRETI, 2'd0, 2'd0, 8'h00);
    do_reset();
    irq_mask_i = 4'b1111;
    for (int a = 0; a < 4; a++) push_exp(8'(a), 4'b0, 1'b0);
    push_exp(8'hF0, 4'b0001, 1'b1);
    push_exp(8'h04, 4'b0000, 1'b0);
    push_exp(8'h05, 4'b0000, 1'b0);
    k = 0;
    do begin @(negedge clk_i); k++; end while (!wfi_o && k < 300);
    wcount = 1; fetched = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk_i);
      if (wfi_o) wcount++;
      if (prog_req_o) fetched = 1'b1;
    end
    irq_i = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (!wfi_o) break;
      wcount++;
      if (prog_req_o) fetched = 1'b1;
    end
    n_checks++;
    if (wcount < 10 || wcount > 11) begin n_fail++; $display("FAIL wfi_duration: got %0d cycles, required 10..11", wcount); end
    n_checks++;
    if (fetched) begin n_fail++; $display("FAIL wfi_no_fetch: request seen while waiting, required none"); end
    wait_obs(exp_q.size(), to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL wfi_timeout: %0d fetches, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      fetch_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL wfi_fetch: got %h/%b/%b, required %h/%b/%b", o.addr, o.ack, o.act, e.addr, e.ack, e.act); end
    end

    // Inside a handler: branch F0->03 (wraps), WFI there, wake without entry.
    fill_nop();
    mem[8'hF0] = ins(opBR, 2'd0, 2'd0, 8'h13);
    mem[3] = ins(opWFI, 2'd0, 2'd0, 8'h00);
    mem[4] = ins(opRETI, 2'd0, 2'd0, 8'h00);
    mem[8'hF2] = ins(opRETI, 2'd0, 2'd0, 8'h00);
    do_reset();
    irq_mask_i = 4'b1111;
    push_exp(8'h00, 4'b0000, 1'b0);
    push_exp(8'hF0, 4'b0001, 1'b1);
    push_exp(8'h03, 4'b0000, 1'b1);
    push_exp(8'h04, 4'b0000, 1'b1);
    push_exp(8'hF2, 4'b0010, 1'b1);
    push_exp(8'h01, 4'b0000, 1'b0);
    push_exp(8'h02, 4'b0000, 1'b0);
    push_exp(8'h03, 4'b0000, 1'b0);
    to = 1'b0;
    wait_fetch(8'h00, to);
    irq_i = 4'b0001;
    k = 0;
    do begin @(negedge clk_i); k++; end while (!wfi_o && k < 300);
    repeat (5) @(negedge clk_i);
    irq_i = 4'b0011;
    wait_obs(exp_q.size(), to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL wfi_noen_timeout: %0d fetches, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      fetch_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL wfi_noen_fetch: got %h/%b/%b, required %h/%b/%b", o.addr, o.ack, o.act, e.addr, e.ack, e.act); end
    end
  endtask

  task automatic test_halt_wrap();
    int k;
    int low_halt;
    bit fetched;
    bit to;
    // Branch to FF, then increment wraps to 0.
    fill_nop();
    mem[1] = ins(opBR, 2'd0, 2'd0, 8'hFE);
    do_reset();
    irq_mask_i = 4'b1111;
    push_exp(8'h00, 4'b0, 1'b0); push_exp(8'h01, 4'b0, 1'b0); push_exp(8'hFF, 4'b0, 1'b0);
    push_exp(8'h00, 4'b0, 1'b0); push_exp(8'h01, 4'b0, 1'b0); push_exp(8'hFF, 4'b0, 1'b0);
    wait_obs(exp_q.size(), to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL wrap_timeout: %0d fetches, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      fetch_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL wrap_fetch: got %h/%b/%b, required %h/%b/%b", o.addr, o.ack, o.act, e.addr, e.ack, e.act); end
    end

    // Halt ignores interrupt edges; only reset restarts the core.
    fill_nop();
    mem[1] = ins(opHALT, 2'd0, 2'd0, 8'h00);
    do_reset();
    irq_mask_i = 4'b1111;
    k = 0;
    do begin @(negedge clk_i); k++; end while (!halt_o && k < 300);
    obs_q.delete();
    low_halt = 0; fetched = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i);
      if (c == 5)  irq_i = 4'b1111;
      if (c == 12) irq_i = 4'b0000;
      if (c == 20) irq_i = 4'b0101;
      if (!halt_o) low_halt++;
      if (prog_req_o) fetched = 1'b1;
    end
    n_checks++;
    if (low_halt != 0) begin n_fail++; $display("FAIL halt_level: halt_o low for %0d cycles, required 0", low_halt); end
    n_checks++;
    if (fetched || obs_q.size() != 0) begin n_fail++; $display("FAIL halt_no_fetch: %0d fetches, required 0", obs_q.size()); end
    // Reset with lines 0 and 2 held high: each yields one edge afterwards.
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if (halt_o !== 1'b0 || prog_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_reset: halt=%b req=%b, required 0 0", halt_o, prog_req_o);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    obs_q.delete();
    exp_q.delete();
    push_exp(8'h00, 4'b0000, 1'b0);
    push_exp(8'hF0, 4'b0001, 1'b1);
    wait_obs(exp_q.size(), to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL halt_restart_timeout: %0d fetches, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      fetch_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL halt_restart_fetch: got %h/%b/%b, required %h/%b/%b", o.addr, o.ack, o.act, e.addr, e.ack, e.act); end
    end
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_priority();
    test_masking();
    test_wfi();
    test_halt_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
